// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, FSM states
// and instruction field offsets.
package id_pkg;

    localparam int ID_WIDTH     = 16;
    localparam int ID_REG_COUNT = 8;
    localparam int ID_OPC_W     = 5;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h09;
    localparam logic [4:0] OP_LDD = 5'h18;
    localparam logic [4:0] OP_STD = 5'h19;
    localparam logic [4:0] OP_LDM = 5'h14;

    typedef enum logic [0:0] {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } id_state_e;

    // rs1 sits directly below the opcode, rs2/rd directly below rs1.
    function automatic int opc_lsb(input int width, input int opc_w);
        return width - opc_w;
    endfunction

    function automatic int rs1_lsb(input int width, input int opc_w, input int reg_aw);
        return width - opc_w - reg_aw;
    endfunction

    function automatic int rs2_lsb(input int width, input int opc_w, input int reg_aw);
        return width - opc_w - (reg_aw + reg_aw);
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode-to-control mapping; unknown opcodes decode as NOP.
module id_ctrl_decode
    import id_pkg::*;
#(
    parameter int OPC_W = ID_OPC_W
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             regwr,
    output logic             alusrc,
    output logic             memr,
    output logic             memwr,
    output logic             is_ldm,
    output logic [OPC_W-1:0] alu_op
);

    // Control table lookup
    always_comb begin
        regwr  = 1'b0;
        alusrc = 1'b0;
        memr   = 1'b0;
        memwr  = 1'b0;
        is_ldm = 1'b0;
        alu_op = '0;
        case (opcode)
            OPC_W'(OP_NOP): begin
                regwr = 1'b0;
            end
            OPC_W'(OP_ADD): begin
                regwr  = 1'b1;
                alu_op = opcode;
            end
            OPC_W'(OP_LDD): begin
                memr   = 1'b1;
                regwr  = 1'b1;
                alusrc = 1'b1;
            end
            OPC_W'(OP_STD): begin
                memwr  = 1'b1;
                alusrc = 1'b1;
            end
            OPC_W'(OP_LDM): begin
                is_ldm = 1'b1;
            end
            default: begin
                regwr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write bypass, two-word LDM
// sequencing, load-use stall, flush/hold, and a registered ID/EX bundle.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int WIDTH     = ID_WIDTH,
    parameter int REG_COUNT = ID_REG_COUNT,
    parameter int OPC_W     = ID_OPC_W,
    parameter int REG_AW    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              ex_memr,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_op1,
    output logic [WIDTH-1:0]  out_op2,
    output logic [WIDTH-1:0]  out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [OPC_W-1:0]  out_alu_op,
    output logic              out_regwr,
    output logic              out_alusrc,
    output logic              out_memr,
    output logic              out_memwr,
    output logic              out_ldm
);

    localparam int OPC_LSB = opc_lsb(WIDTH, OPC_W);
    localparam int RS1_LSB = rs1_lsb(WIDTH, OPC_W, REG_AW);
    localparam int RS2_LSB = rs2_lsb(WIDTH, OPC_W, REG_AW);

    logic [WIDTH-1:0]  rf_r [REG_COUNT];
    id_state_e         state_r, state_n_s;
    logic [REG_AW-1:0] ldm_rd_r, ldm_rd_n_s;

    logic [OPC_W-1:0]  opcode_s;
    logic [REG_AW-1:0] rs1_s, rs2_s;
    logic [WIDTH-1:0]  rd1_s, rd2_s;
    logic              stall_s, accept_s;

    logic              dec_regwr_s, dec_alusrc_s, dec_memr_s, dec_memwr_s, dec_ldm_s;
    logic [OPC_W-1:0]  dec_alu_op_s;

    logic              valid_n_s, regwr_n_s, alusrc_n_s, memr_n_s, memwr_n_s, ldm_n_s;
    logic [WIDTH-1:0]  imm_n_s;
    logic [REG_AW-1:0] rd_n_s;
    logic [OPC_W-1:0]  alu_op_n_s;

    assign opcode_s = instr[OPC_LSB +: OPC_W];
    assign rs1_s    = instr[RS1_LSB +: REG_AW];
    assign rs2_s    = instr[RS2_LSB +: REG_AW];

    // A write landing this cycle is visible to the read in the same cycle.
    assign rd1_s = (wb_en && (wb_addr == rs1_s)) ? wb_data : rf_r[rs1_s];
    assign rd2_s = (wb_en && (wb_addr == rs2_s)) ? wb_data : rf_r[rs2_s];

    // The immediate word of an LDM carries no register fields, so no stall there.
    assign stall_s  = (state_r == S_OP) && in_valid && ex_memr &&
                      ((rs1_s == ex_rd) || (rs2_s == ex_rd));
    assign in_ready = rst && en && !flush && !stall_s;
    assign accept_s = in_valid && in_ready;

    id_ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode (opcode_s),
        .regwr  (dec_regwr_s),
        .alusrc (dec_alusrc_s),
        .memr   (dec_memr_s),
        .memwr  (dec_memwr_s),
        .is_ldm (dec_ldm_s),
        .alu_op (dec_alu_op_s)
    );

    // Register file storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_r[i] <= '0;
            end
        end else if (en && wb_en) begin
            rf_r[wb_addr] <= wb_data;
        end
    end

    // Next-state and next-bundle selection; a bubble is the default
    always_comb begin
        state_n_s  = state_r;
        ldm_rd_n_s = ldm_rd_r;
        valid_n_s  = 1'b0;
        regwr_n_s  = 1'b0;
        alusrc_n_s = 1'b0;
        memr_n_s   = 1'b0;
        memwr_n_s  = 1'b0;
        ldm_n_s    = 1'b0;
        imm_n_s    = '0;
        rd_n_s     = '0;
        alu_op_n_s = '0;
        if (flush) begin
            state_n_s  = S_OP;
            ldm_rd_n_s = '0;
        end else if (accept_s) begin
            case (state_r)
                S_OP: begin
                    if (dec_ldm_s) begin
                        state_n_s  = S_IMM;
                        ldm_rd_n_s = rs2_s;
                    end else begin
                        valid_n_s  = 1'b1;
                        regwr_n_s  = dec_regwr_s;
                        alusrc_n_s = dec_alusrc_s;
                        memr_n_s   = dec_memr_s;
                        memwr_n_s  = dec_memwr_s;
                        alu_op_n_s = dec_alu_op_s;
                        rd_n_s     = rs2_s;
                    end
                end
                S_IMM: begin
                    state_n_s  = S_OP;
                    ldm_rd_n_s = '0;
                    valid_n_s  = 1'b1;
                    imm_n_s    = instr;
                    ldm_n_s    = 1'b1;
                    regwr_n_s  = 1'b1;
                    alusrc_n_s = 1'b1;
                    rd_n_s     = ldm_rd_r;
                end
                default: begin
                    state_n_s  = S_OP;
                    ldm_rd_n_s = '0;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // FSM state and ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_OP;
            ldm_rd_r   <= '0;
            out_valid  <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
            out_alu_op <= '0;
            out_regwr  <= 1'b0;
            out_alusrc <= 1'b0;
            out_memr   <= 1'b0;
            out_memwr  <= 1'b0;
            out_ldm    <= 1'b0;
        end else if (en) begin
            state_r    <= state_n_s;
            ldm_rd_r   <= ldm_rd_n_s;
            out_valid  <= valid_n_s;
            out_op1    <= rd1_s;
            out_op2    <= rd2_s;
            out_imm    <= imm_n_s;
            out_rd     <= rd_n_s;
            out_alu_op <= alu_op_n_s;
            out_regwr  <= regwr_n_s;
            out_alusrc <= alusrc_n_s;
            out_memr   <= memr_n_s;
            out_memwr  <= memwr_n_s;
            out_ldm    <= ldm_n_s;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus a randomized
// run against a rule-level reference model.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst, en, flush, in_valid, wb_en, ex_memr;
    logic [15:0] instr, wb_data;
    logic [2:0]  wb_addr, ex_rd;
    logic        in_ready, out_valid, out_regwr, out_alusrc, out_memr, out_memwr, out_ldm;
    logic [15:0] out_op1, out_op2, out_imm;
    logic [2:0]  out_rd;
    logic [4:0]  out_alu_op;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_rf [8];
    bit          m_pend;
    logic [2:0]  m_pend_rd;
    logic        e_valid, e_regwr, e_alusrc, e_memr, e_memwr, e_ldm;
    logic [15:0] e_op1, e_op2, e_imm;
    logic [2:0]  e_rd;
    logic [4:0]  e_alu;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .instr(instr), .in_ready(in_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_memr(ex_memr), .ex_rd(ex_rd), .out_valid(out_valid),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
        .out_alu_op(out_alu_op), .out_regwr(out_regwr), .out_alusrc(out_alusrc),
        .out_memr(out_memr), .out_memwr(out_memwr), .out_ldm(out_ldm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        bit haz;
        haz = !m_pend && in_valid && ex_memr && (instr[10:8] == ex_rd || instr[7:5] == ex_rd);
        return rst && en && !flush && !haz;
    endfunction

    // Advance one clock; the model applies the rules to the inputs seen at this edge.
    task automatic step();
        logic [4:0]  opc;
        logic [2:0]  a1, a2;
        logic [15:0] r1, r2;
        bit          acc;
        opc = instr[15:11];
        a1  = instr[10:8];
        a2  = instr[7:5];
        acc = in_valid && m_ready();
        if (!rst) begin
            foreach (m_rf[i]) m_rf[i] = 16'h0;
            m_pend = 1'b0; m_pend_rd = 3'd0;
            {e_valid, e_regwr, e_alusrc, e_memr, e_memwr, e_ldm} = 6'b0;
            e_op1 = 16'h0; e_op2 = 16'h0; e_imm = 16'h0; e_rd = 3'd0; e_alu = 5'd0;
        end else if (en) begin
            r1 = (wb_en && wb_addr == a1) ? wb_data : m_rf[a1];
            r2 = (wb_en && wb_addr == a2) ? wb_data : m_rf[a2];
            {e_valid, e_regwr, e_alusrc, e_memr, e_memwr, e_ldm} = 6'b0;
            e_op1 = r1; e_op2 = r2; e_imm = 16'h0; e_rd = 3'd0; e_alu = 5'd0;
            if (flush) begin
                m_pend = 1'b0;
            end else if (acc && m_pend) begin
                e_valid = 1'b1; e_imm = instr; e_ldm = 1'b1; e_regwr = 1'b1;
                e_alusrc = 1'b1; e_rd = m_pend_rd; m_pend = 1'b0;
            end else if (acc && opc == 5'h14) begin
                m_pend = 1'b1; m_pend_rd = a2;
            end else if (acc) begin
                e_valid = 1'b1; e_rd = a2;
                case (opc)
                    5'h09: begin e_regwr = 1'b1; e_alu = opc; end
                    5'h18: begin e_memr = 1'b1; e_regwr = 1'b1; e_alusrc = 1'b1; end
                    5'h19: begin e_memwr = 1'b1; e_alusrc = 1'b1; end
                    default: ;
                endcase
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; ex_memr = 1'b0;
        instr = 16'h0; wb_addr = 3'd0; wb_data = 16'h0; ex_rd = 3'd0;
    endtask

    task automatic test_reset();
        logic [15:0] o;
        idle();
        rst = 1'b0; in_valid = 1'b1; instr = 16'(($urandom));
        step(); step();
        o = out_op1 | out_op2 | out_imm;
        total++;
        if ({out_valid, out_regwr, out_alusrc, out_memr, out_memwr, out_ldm, out_rd, out_alu_op, in_ready} !== 15'h0 || o !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b ready=%b ops=%h want all 0", out_valid, in_ready, o);
        end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = {5'h09, 3'(i), 3'(7 - i), 5'd0};
            step();
            total++;
            if (out_valid !== 1'b1 || out_op1 !== 16'h0 || out_op2 !== 16'h0) begin
                bad++;
                $display("FAIL reset_regread%0d: got valid=%b op1=%h op2=%h want 1/0/0", i, out_valid, out_op1, out_op2);
            end
        end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        in_valid = 1'b1; instr = {5'h09, 3'd3, 3'd0, 5'd0};
        step();
        total++;
        if (out_valid !== 1'b1 || out_op1 !== 16'hBEEF || out_regwr !== 1'b1 || out_alu_op !== 5'h09) begin
            bad++;
            $display("FAIL bypass: got valid=%b op1=%h regwr=%b alu=%h want 1/beef/1/09", out_valid, out_op1, out_regwr, out_alu_op);
        end
        idle();
    endtask

    task automatic test_ldm();
        idle();
        in_valid = 1'b1; instr = {5'h14, 3'd0, 3'd2, 5'd0};
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ldm_first: got valid=%b want 0", out_valid); end
        instr = 16'h1234; ex_memr = 1'b1; ex_rd = 3'd2;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ldm_no_hazard: got ready=%b want 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_imm !== 16'h1234 || out_rd !== 3'd2 || out_ldm !== 1'b1 ||
            out_alusrc !== 1'b1 || out_regwr !== 1'b1 || out_memr !== 1'b0) begin
            bad++;
            $display("FAIL ldm_second: got valid=%b imm=%h rd=%0d ldm=%b alusrc=%b regwr=%b want 1/1234/2/1/1/1",
                     out_valid, out_imm, out_rd, out_ldm, out_alusrc, out_regwr);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        ex_memr = 1'b1; ex_rd = 3'd5;
        in_valid = 1'b1; instr = {5'h09, 3'd1, 3'd5, 5'd0};
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL loaduse_ready: got %b want 0", in_ready); end
        step();
        total++;
        if ({out_valid, out_regwr, out_alusrc, out_memr, out_memwr, out_ldm} !== 6'b0) begin
            bad++; $display("FAIL loaduse_bubble: got valid=%b regwr=%b want 0/0", out_valid, out_regwr);
        end
        ex_memr = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL loaduse_release: got %b want 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_regwr !== 1'b1 || out_rd !== 3'd5) begin
            bad++; $display("FAIL loaduse_accept: got valid=%b regwr=%b rd=%0d want 1/1/5", out_valid, out_regwr, out_rd);
        end
        idle();
    endtask

    task automatic test_flush_imm();
        idle();
        in_valid = 1'b1; instr = {5'h14, 3'd0, 3'd6, 5'd0};
        step();
        flush = 1'b1; instr = 16'h1234;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b0 || out_ldm !== 1'b0) begin
            bad++; $display("FAIL flush_bubble: got valid=%b ldm=%b want 0/0", out_valid, out_ldm);
        end
        flush = 1'b0; instr = 16'h4800;
        step();
        total++;
        if (out_valid !== 1'b1 || out_ldm !== 1'b0 || out_regwr !== 1'b1 || out_alu_op !== 5'h09 || out_imm !== 16'h0) begin
            bad++;
            $display("FAIL flush_decode: got valid=%b ldm=%b regwr=%b alu=%h imm=%h want 1/0/1/09/0000",
                     out_valid, out_ldm, out_regwr, out_alu_op, out_imm);
        end
        idle();
    endtask

    task automatic test_hold();
        idle();
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h5555;
        in_valid = 1'b1; instr = {5'h18, 3'd2, 3'd3, 5'd0};
        step();
        en = 1'b0; wb_data = 16'hFFFF; instr = {5'h19, 3'd1, 3'd1, 5'd0};
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d: got %b want 0", i, in_ready); end
            step();
            total++;
            if (out_valid !== 1'b1 || out_memr !== 1'b1 || out_memwr !== 1'b0 || out_rd !== 3'd3 || out_op1 !== e_op1) begin
                bad++;
                $display("FAIL hold_outputs%0d: got valid=%b memr=%b memwr=%b rd=%0d op1=%h want 1/1/0/3/%h",
                         i, out_valid, out_memr, out_memwr, out_rd, out_op1, e_op1);
            end
        end
        en = 1'b1; wb_en = 1'b0; instr = {5'h09, 3'd1, 3'd0, 5'd0};
        step();
        total++;
        if (out_op1 !== 16'h5555) begin bad++; $display("FAIL hold_rf: got %h want 5555", out_op1); end
        idle();
    endtask

    task automatic test_random();
        logic [4:0] pool [6];
        pool = '{5'h00, 5'h09, 5'h18, 5'h19, 5'h14, 5'h00};
        for (int n = 0; n < 400; n++) begin
            pool[5] = 5'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            instr    = {pool[$urandom_range(0, 5)], 11'($urandom)};
            wb_en    = 1'($urandom);
            wb_addr  = 3'($urandom);
            wb_data  = 16'($urandom);
            ex_memr  = ($urandom_range(0, 2) == 0);
            ex_rd    = 3'($urandom);
            #1;
            total++;
            if (in_ready !== m_ready()) begin
                bad++; $display("FAIL rand_ready@%0d: got %b want %b", n, in_ready, m_ready());
            end
            step();
            total++;
            if ({out_valid, out_regwr, out_alusrc, out_memr, out_memwr, out_ldm, out_alu_op, out_imm} !==
                {e_valid, e_regwr, e_alusrc, e_memr, e_memwr, e_ldm, e_alu, e_imm} ||
                (e_valid && (out_rd !== e_rd || out_op1 !== e_op1 || out_op2 !== e_op2))) begin
                bad++;
                $display("FAIL rand_bundle@%0d: got v=%b ctl=%b%b%b%b%b alu=%h imm=%h rd=%0d op=%h/%h want v=%b ctl=%b%b%b%b%b alu=%h imm=%h rd=%0d op=%h/%h",
                         n, out_valid, out_regwr, out_alusrc, out_memr, out_memwr, out_ldm, out_alu_op, out_imm, out_rd, out_op1, out_op2,
                         e_valid, e_regwr, e_alusrc, e_memr, e_memwr, e_ldm, e_alu, e_imm, e_rd, e_op1, e_op2);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_ldm();
        test_load_use();
        test_flush_imm();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
